// File: rtl/tdc_pkg.sv
// Shared widths, types and the popcount helper for the ring-oscillator TDC back end.
package tdc_pkg;
  localparam int PHASES   = 16;
  localparam int CNT_W    = 7;
  localparam int CAL_LOG2 = 6;
  localparam int FINE_W   = $clog2(2 * PHASES);
  localparam int WORD_W   = CNT_W + FINE_W;
  localparam int CAL_W    = WORD_W + CAL_LOG2;

  typedef logic [WORD_W-1:0]   tdc_word_t;
  typedef logic [FINE_W-1:0]   tdc_fine_t;
  typedef logic [CAL_W-1:0]    tdc_cal_t;
  typedef logic [CAL_LOG2-1:0] tdc_cal_cnt_t;

  // FINE_W bits hold 0..PHASES because PHASES is a power of two.
  function automatic tdc_fine_t popcount(input logic [PHASES-1:0] v);
    tdc_fine_t n;
    n = '0;
    for (int i = 0; i < PHASES; i++) n = n + tdc_fine_t'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/tdc_therm_decoder.sv
// Circular thermometer decoder: popcount-based fine code plus ring transition check.
module tdc_therm_decoder
  import tdc_pkg::*;
(
  input  logic [PHASES-1:0] phase,
  output tdc_fine_t         fine,
  output logic              bubble
);

  tdc_fine_t         pc;
  tdc_fine_t         trans;
  logic [PHASES-1:0] rot;

  always_comb begin
    pc    = popcount(phase);
    // Neighbour compare includes the wrap from the top phase back to phase[0].
    rot   = {phase[0], phase[PHASES-1:1]};
    trans = popcount(phase ^ rot);
    if (phase[0]) fine = pc - tdc_fine_t'(1);
    else          fine = tdc_fine_t'(2 * PHASES - 1) - pc;
    bubble = (trans != tdc_fine_t'(0)) && (trans != tdc_fine_t'(2));
  end

endmodule

// File: rtl/tdc_digital_decoder.sv
// TDC back end: register, decode to a word, difference consecutive words and
// accumulate the deltas over a calibration window.
module tdc_digital_decoder
  import tdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  ripple_count,
  input  logic [PHASES-1:0] phase,
  output tdc_fine_t         fine,
  output tdc_word_t         word,
  output tdc_word_t         delta,
  output logic              delta_valid,
  output logic              bubble_err,
  output tdc_cal_t          cal_period,
  output logic              cal_valid
);

  logic [CNT_W-1:0]  s1_count;
  logic [PHASES-1:0] s1_phase;
  logic              s1_en;
  tdc_fine_t         dec_fine;
  logic              dec_bubble;
  logic              s2_bubble;
  logic              s2_en;
  tdc_word_t         prev;
  logic              primed;
  tdc_cal_t          acc;
  tdc_cal_cnt_t      cnt;
  tdc_word_t         diff;
  tdc_cal_t          acc_sum;

  tdc_therm_decoder u_therm (
    .phase  (s1_phase),
    .fine   (dec_fine),
    .bubble (dec_bubble)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_count  <= '0;
      s1_phase  <= '0;
      s1_en     <= 1'b0;
      fine      <= '0;
      word      <= '0;
      s2_bubble <= 1'b0;
      s2_en     <= 1'b0;
    end else begin
      s1_count  <= ripple_count;
      s1_phase  <= phase;
      s1_en     <= en;
      fine      <= dec_fine;
      word      <= {s1_count, dec_fine};
      s2_bubble <= dec_bubble;
      s2_en     <= s1_en;
    end
  end

  // Modular subtraction gives the right delta across a ripple counter wrap.
  assign diff    = word - prev;
  assign acc_sum = acc + tdc_cal_t'(diff);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev        <= '0;
      primed      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      delta       <= '0;
      delta_valid <= 1'b0;
      bubble_err  <= 1'b0;
      cal_period  <= '0;
      cal_valid   <= 1'b0;
    end else begin
      delta_valid <= 1'b0;
      bubble_err  <= 1'b0;
      cal_valid   <= 1'b0;
      if (!s2_en) begin
        primed <= 1'b0;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        prev   <= word;
        primed <= 1'b1;
        if (primed) begin
          delta       <= diff;
          delta_valid <= 1'b1;
          bubble_err  <= s2_bubble;
          cnt         <= cnt + tdc_cal_cnt_t'(1);
          // Last sample of the window closes it and restarts the sum.
          if (cnt == '1) begin
            cal_period <= acc_sum;
            cal_valid  <= 1'b1;
            acc        <= '0;
          end else begin
            acc <= acc_sum;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_digital_decoder.sv
// Directed bench for tdc_digital_decoder with hand-computed expectations.
module tb_tdc_digital_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [6:0]  ripple_count;
  logic [15:0] phase;
  logic [4:0]  fine;
  logic [11:0] word;
  logic [11:0] delta;
  logic        delta_valid;
  logic        bubble_err;
  logic [17:0] cal_period;
  logic        cal_valid;

  int n_cmp = 0;
  int n_err = 0;

  tdc_digital_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ripple_count (ripple_count),
    .phase        (phase),
    .fine         (fine),
    .word         (word),
    .delta        (delta),
    .delta_valid  (delta_valid),
    .bubble_err   (bubble_err),
    .cal_period   (cal_period),
    .cal_valid    (cal_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Thermometer code for a fine value: 1^k0^(16-k) below 16, 0^k1^(16-k) from 16.
  function automatic logic [15:0] phase_of(input int f);
    int t;
    if (f < 16) t = (1 << (f + 1)) - 1;
    else        t = (32'hFFFF << (f - 15)) & 32'hFFFF;
    return t[15:0];
  endfunction

  task automatic drive(input logic [6:0] c, input logic [15:0] p, input logic e);
    ripple_count = c;
    phase        = p;
    en           = e;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input int w, input logic e);
    logic [11:0] wm;
    wm = 12'(w);
    drive(wm[11:5], phase_of(int'(wm[4:0])), e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fine"}, 32'(fine), 0);
    chk({tag, "_word"}, 32'(word), 0);
    chk({tag, "_delta"}, 32'(delta), 0);
    chk({tag, "_dv"}, 32'(delta_valid), 0);
    chk({tag, "_bub"}, 32'(bubble_err), 0);
    chk({tag, "_calp"}, 32'(cal_period), 0);
    chk({tag, "_calv"}, 32'(cal_valid), 0);
  endtask

  // en=0 sample, then nsamp enabled samples stepping the word by 100.
  task automatic cal_run(input string tag, input int w0, input int nsamp,
                         input int exp_pulses, input int held_period);
    int pulses;
    int jv;
    pulses = 0;
    drive_word(w0, 1'b0);
    for (int s = 1; s <= nsamp; s++) begin
      drive_word(w0 + 100 * (s - 1), 1'b1);
      jv = s - 3;
      if (jv == -1 || jv == 0) begin
        chk({tag, "_gap_dv"}, 32'(delta_valid), 0);
        chk({tag, "_gap_calv"}, 32'(cal_valid), 0);
        chk({tag, "_held_calp"}, 32'(cal_period), held_period);
      end else if (jv >= 1) begin
        chk({tag, "_dv"}, 32'(delta_valid), 1);
        chk({tag, "_delta"}, 32'(delta), 100);
        chk({tag, "_calv"}, 32'(cal_valid), (jv % 64 == 0) ? 1 : 0);
        if (jv % 64 == 0) chk({tag, "_calp"}, 32'(cal_period), 6400);
        if (cal_valid) pulses++;
      end
    end
    chk({tag, "_pulses"}, pulses, exp_pulses);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    ripple_count = '0;
    phase = '0;

    // Reset with random inputs and en high.
    for (int i = 0; i < 3; i++) begin
      drive(7'($urandom), 16'($urandom), 1'b1);
      chk_all_zero("reset");
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(7'($urandom), 16'($urandom), 1'b1);
      chk("rel_dv_low", 32'(delta_valid), 0);
    end
    drive(7'($urandom), 16'($urandom), 1'b1);
    chk("rel_dv_4clk", 32'(delta_valid), 1);

    // Fine sweep through all 32 thermometer codes.
    for (int i = 0; i <= 32; i++) begin
      drive(7'd0, (i < 32) ? phase_of(i) : 16'h0001, 1'b1);
      if (i >= 1) chk("sweep_fine", 32'(fine), i - 1);
      if (i >= 2) chk("sweep_bub", 32'(bubble_err), 0);
    end

    // Wrap: 127/30 -> 1/2.
    drive(7'd127, 16'h8000, 1'b1);
    drive(7'd1, 16'h0007, 1'b1);
    chk("wrap_word_a", 32'(word), 4094);
    chk("wrap_fine_a", 32'(fine), 30);
    drive(7'd1, 16'h0007, 1'b1);
    chk("wrap_word_b", 32'(word), 34);
    drive(7'd1, 16'h0007, 1'b1);
    chk("wrap_delta", 32'(delta), 36);
    chk("wrap_dv", 32'(delta_valid), 1);
    chk("wrap_bub", 32'(bubble_err), 0);

    // Bubble code 0x00F5: popcount 6, six ring transitions.
    drive(7'd0, 16'h00F5, 1'b1);
    drive(7'd0, 16'h0001, 1'b1);
    chk("bub_fine", 32'(fine), 5);
    chk("bub_word", 32'(word), 5);
    drive(7'd0, 16'h0001, 1'b1);
    chk("bub_flag", 32'(bubble_err), 1);
    chk("bub_dv", 32'(delta_valid), 1);
    chk("bub_delta", 32'(delta), 4067);
    drive(7'd0, 16'h0001, 1'b1);
    chk("bub_clear", 32'(bubble_err), 0);
    chk("bub_delta2", 32'(delta), 4091);

    // Two full windows, then an en drop mid-window restarts the count.
    cal_run("cal1", 200, 131, 2, 0);
    cal_run("cal2", 4000, 70, 1, 6400);

    // Reset mid-operation.
    rst = 1'b1;
    drive(7'd5, 16'h00FF, 1'b1);
    chk_all_zero("midrst");
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
